digit_scan_ctrl: RTL and testbench

DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

---
 rtl/scan_pkg.sv | 38 +++
 rtl/scan_tick_gen.sv | 31 +++
 rtl/digit_scan_ctrl.sv | 94 +++++++++
 tb/tb_digit_scan_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared constants, FSM state type and snapshot record for the digit scanner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package scan_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

    typedef enum logic {
        GUARD = 1'b0,
        ON    = 1'b1
    } scan_state_t;

    // Frame snapshot: everything that must stay stable for one full frame.
    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] digits;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   en;
    } snap_t;

    // Digits that may light: enabled and not a blanked leading zero.
    // Digit i is a leading zero when it and every digit above it are zero;
    // digit0 is always allowed so a value of zero still shows "0".
    function automatic logic [NUM_DIGITS-1:0] visible_mask(input snap_t s, input logic lz);
        logic [NUM_DIGITS-1:0] vis;
        logic                  zero_above;
        vis        = s.en;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (s.digits[4*i +: 4] == 4'h0);
            if (lz && zero_above) begin
                vis[i] = 1'b0;
            end
        end
        return vis;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Slot counter 0..REFRESH_DIV-1 with a terminal-count wrap strobe.
// Latency: wrap is combinational from slot_cnt (high during the last cycle of a slot).
// Backpressure: none; free-running.
// Ports: clk, clr (async active-low), slot_cnt (current slot position), wrap.
module scan_tick_gen
    import scan_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic             clk,
    input  logic             clr,
    output logic [CNT_W-1:0] slot_cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(REFRESH_DIV - 1);

    assign wrap = (slot_cnt == TERM_CNT);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            slot_cnt <= '0;
        end else if (wrap) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with anode guard band.
// Latency: outputs registered; hex/dp/idx change on the slot-wrap edge, an enables BLANK_CYCLES later.
// Backpressure: none; inputs sampled once per frame into a snapshot.
// Ports: clk, clr (async active-low), digits_in/dp_in/digit_en/lz_blank in;
//        hex_out, dp_out, an (active-low), digit_idx, frame_tick out.
module digit_scan_ctrl
    import scan_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    output logic [3:0]              hex_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [1:0]              digit_idx,
    output logic                    frame_tick
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(BLANK_CYCLES - 1);

    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_params
        $error("digit_scan_ctrl: BLANK_CYCLES must be in 1..REFRESH_DIV-1");
    end

    logic [CNT_W-1:0]      slot_cnt;
    logic                  wrap;
    logic                  frame_start;
    logic [1:0]            idx_nxt;
    snap_t                 snap;
    snap_t                 snap_nxt;
    logic [NUM_DIGITS-1:0] vis_cur;
    logic [NUM_DIGITS-1:0] vis_nxt;
    scan_state_t           state;

    scan_tick_gen #(
        .REFRESH_DIV (REFRESH_DIV),
        .CNT_W       (CNT_W)
    ) u_tick (
        .clk      (clk),
        .clr      (clr),
        .slot_cnt (slot_cnt),
        .wrap     (wrap)
    );

    // The 3->0 index wrap is the frame boundary where the snapshot reloads.
    assign frame_start = wrap && (digit_idx == 2'd3);
    assign idx_nxt     = wrap ? digit_idx + 2'd1 : digit_idx;

    always_comb begin
        snap_nxt = snap;
        if (frame_start) begin
            snap_nxt.digits = digits_in;
            snap_nxt.dp     = dp_in;
            snap_nxt.en     = digit_en;
        end
    end

    assign vis_cur = visible_mask(snap, lz_blank);
    // Used on the wrap edge so hex/dp for slot 0 come from the fresh snapshot.
    assign vis_nxt = visible_mask(snap_nxt, lz_blank);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= GUARD;
            digit_idx  <= 2'd0;
            snap       <= '0;
            an         <= ANODE_OFF;
            hex_out    <= 4'h0;
            dp_out     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_start;
            snap       <= snap_nxt;
            if (wrap) begin
                state     <= GUARD;
                an        <= ANODE_OFF;
                digit_idx <= idx_nxt;
                hex_out   <= vis_nxt[idx_nxt] ? snap_nxt.digits[{idx_nxt, 2'b00} +: 4] : 4'h0;
                dp_out    <= vis_nxt[idx_nxt] & snap_nxt.dp[idx_nxt];
            end else if (state == GUARD && slot_cnt == GUARD_LAST) begin
                state <= ON;
                an    <= vis_cur[digit_idx] ? (ANODE_OFF & ~(4'b0001 << digit_idx)) : ANODE_OFF;
            end
        end
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed self-checking bench for digit_scan_ctrl at REFRESH_DIV=8, BLANK_CYCLES=2.
// Latency: positions counted in clock edges since reset release (8 per slot, 32 per frame).
// Backpressure: n/a.
module tb_digit_scan_ctrl;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] digits_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  digit_en = 4'h0;
    logic        lz_blank = 1'b0;
    logic [3:0]  hex_out;
    logic        dp_out;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int checks = 0;
    int passes = 0;
    int pos = 0;

    always #5 clk = ~clk;

    digit_scan_ctrl #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .lz_blank   (lz_blank),
        .hex_out    (hex_out),
        .dp_out     (dp_out),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    // Hold reset a few cycles, then release just after an edge; pos 0 = that point.
    task automatic apply_reset();
        clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 clr = 1'b1;
        pos = 0;
    endtask

    task automatic goto(input int p);
        while (pos < p) begin
            @(posedge clk);
            #1;
            pos++;
        end
    endtask

    task automatic test_reset();
        digits_in = 16'h1234; digit_en = 4'hF; dp_in = 4'h0; lz_blank = 1'b0;
        clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (an !== 4'b1111) $display("FAIL reset_an: got %b want 1111", an); else passes++;
        checks++; if (hex_out !== 4'h0) $display("FAIL reset_hex: got %h want 0", hex_out); else passes++;
        checks++; if (dp_out !== 1'b0) $display("FAIL reset_dp: got %b want 0", dp_out); else passes++;
        checks++; if (digit_idx !== 2'd0) $display("FAIL reset_idx: got %0d want 0", digit_idx); else passes++;
        checks++; if (frame_tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", frame_tick); else passes++;
        clr = 1'b1;
        pos = 0;
        // Snapshot is still zero during frame 0, so nothing lights.
        for (int p = 0; p < 32; p++) begin
            goto(p);
            checks++; if (an !== 4'b1111) $display("FAIL frame0_an p=%0d: got %b want 1111", p, an); else passes++;
        end
        goto(32);
        checks++; if (frame_tick !== 1'b1) $display("FAIL first_tick: got %b want 1", frame_tick); else passes++;
        checks++; if (digit_idx !== 2'd0) $display("FAIL first_tick_idx: got %0d want 0", digit_idx); else passes++;
        checks++; if (hex_out !== 4'h4) $display("FAIL slot0_guard_hex: got %h want 4", hex_out); else passes++;
        checks++; if (an !== 4'b1111) $display("FAIL slot0_guard_an: got %b want 1111", an); else passes++;
        goto(33);
        checks++; if (frame_tick !== 1'b0) $display("FAIL tick_width: got %b want 0", frame_tick); else passes++;
        checks++; if (an !== 4'b1111) $display("FAIL slot0_guard1_an: got %b want 1111", an); else passes++;
        for (int p = 34; p < 40; p++) begin
            goto(p);
            checks++; if (an !== 4'b1110) $display("FAIL slot0_on_an p=%0d: got %b want 1110", p, an); else passes++;
            checks++; if (hex_out !== 4'h4) $display("FAIL slot0_on_hex p=%0d: got %h want 4", p, hex_out); else passes++;
        end
        goto(40);
        checks++; if (digit_idx !== 2'd1) $display("FAIL slot1_idx: got %0d want 1", digit_idx); else passes++;
        checks++; if (an !== 4'b1111) $display("FAIL slot1_guard_an: got %b want 1111", an); else passes++;
        goto(42);
        checks++; if (an !== 4'b1101) $display("FAIL slot1_an: got %b want 1101", an); else passes++;
        checks++; if (hex_out !== 4'h3) $display("FAIL slot1_hex: got %h want 3", hex_out); else passes++;
        goto(58);
        checks++; if (an !== 4'b0111) $display("FAIL slot3_an: got %b want 0111", an); else passes++;
        checks++; if (hex_out !== 4'h1) $display("FAIL slot3_hex: got %h want 1", hex_out); else passes++;
        checks++; if (digit_idx !== 2'd3) $display("FAIL slot3_idx: got %0d want 3", digit_idx); else passes++;
        goto(64);
        checks++; if (frame_tick !== 1'b1) $display("FAIL second_tick: got %b want 1", frame_tick); else passes++;
    endtask

    task automatic test_lz_blank();
        digits_in = 16'h0050; digit_en = 4'hF; dp_in = 4'h0; lz_blank = 1'b1;
        apply_reset();
        goto(34);
        checks++; if (an !== 4'b1110) $display("FAIL lz_d0_an: got %b want 1110", an); else passes++;
        checks++; if (hex_out !== 4'h0) $display("FAIL lz_d0_hex: got %h want 0", hex_out); else passes++;
        goto(42);
        checks++; if (an !== 4'b1101) $display("FAIL lz_d1_an: got %b want 1101", an); else passes++;
        checks++; if (hex_out !== 4'h5) $display("FAIL lz_d1_hex: got %h want 5", hex_out); else passes++;
        goto(50);
        checks++; if (an !== 4'b1111) $display("FAIL lz_d2_an: got %b want 1111", an); else passes++;
        checks++; if (hex_out !== 4'h0) $display("FAIL lz_d2_hex: got %h want 0", hex_out); else passes++;
        goto(58);
        checks++; if (an !== 4'b1111) $display("FAIL lz_d3_an: got %b want 1111", an); else passes++;
        lz_blank = 1'b0;
    endtask

    task automatic test_snapshot();
        digits_in = 16'h1111; digit_en = 4'hF; dp_in = 4'h0; lz_blank = 1'b0;
        apply_reset();
        goto(40);
        digits_in = 16'h2222;
        goto(42);
        checks++; if (hex_out !== 4'h1) $display("FAIL snap_mid_d1_hex: got %h want 1", hex_out); else passes++;
        goto(50);
        checks++; if (hex_out !== 4'h1) $display("FAIL snap_mid_d2_hex: got %h want 1", hex_out); else passes++;
        goto(58);
        checks++; if (hex_out !== 4'h1) $display("FAIL snap_mid_d3_hex: got %h want 1", hex_out); else passes++;
        checks++; if (an !== 4'b0111) $display("FAIL snap_mid_d3_an: got %b want 0111", an); else passes++;
        goto(66);
        checks++; if (hex_out !== 4'h2) $display("FAIL snap_next_d0_hex: got %h want 2", hex_out); else passes++;
        checks++; if (an !== 4'b1110) $display("FAIL snap_next_d0_an: got %b want 1110", an); else passes++;
        goto(74);
        checks++; if (hex_out !== 4'h2) $display("FAIL snap_next_d1_hex: got %h want 2", hex_out); else passes++;
    endtask

    task automatic test_all_disabled();
        digits_in = 16'h1234; digit_en = 4'h0; dp_in = 4'hF; lz_blank = 1'b0;
        apply_reset();
        for (int p = 0; p < 128; p++) begin
            goto(p);
            checks++; if (an !== 4'b1111) $display("FAIL dis_an p=%0d: got %b want 1111", p, an); else passes++;
            checks++; if (digit_idx !== 2'((p / 8) % 4)) $display("FAIL dis_idx p=%0d: got %0d want %0d", p, digit_idx, (p / 8) % 4); else passes++;
            checks++; if (frame_tick !== ((p % 32 == 0) && (p > 0))) $display("FAIL dis_tick p=%0d: got %b want %b", p, frame_tick, ((p % 32 == 0) && (p > 0))); else passes++;
        end
    endtask

    task automatic test_mid_reset();
        digits_in = 16'h1234; digit_en = 4'hF; dp_in = 4'h4; lz_blank = 1'b0;
        apply_reset();
        goto(53);
        checks++; if (an !== 4'b1011) $display("FAIL pre_rst_an: got %b want 1011", an); else passes++;
        checks++; if (hex_out !== 4'h2) $display("FAIL pre_rst_hex: got %h want 2", hex_out); else passes++;
        #2 clr = 1'b0;
        #1;
        checks++; if (an !== 4'b1111) $display("FAIL async_rst_an: got %b want 1111", an); else passes++;
        checks++; if (hex_out !== 4'h0) $display("FAIL async_rst_hex: got %h want 0", hex_out); else passes++;
        checks++; if (dp_out !== 1'b0) $display("FAIL async_rst_dp: got %b want 0", dp_out); else passes++;
        checks++; if (digit_idx !== 2'd0) $display("FAIL async_rst_idx: got %0d want 0", digit_idx); else passes++;
        @(posedge clk);
        #1 clr = 1'b1;
        pos = 0;
        for (int p = 0; p < 8; p++) begin
            goto(p);
            checks++; if (an !== 4'b1111) $display("FAIL rst_slot0_an p=%0d: got %b want 1111", p, an); else passes++;
            checks++; if (digit_idx !== 2'd0) $display("FAIL rst_slot0_idx p=%0d: got %0d want 0", p, digit_idx); else passes++;
        end
        goto(8);
        checks++; if (digit_idx !== 2'd1) $display("FAIL rst_slot1_idx: got %0d want 1", digit_idx); else passes++;
    endtask

    task automatic test_dp();
        digits_in = 16'h1234; digit_en = 4'hF; dp_in = 4'b0100; lz_blank = 1'b0;
        apply_reset();
        for (int p = 32; p < 64; p++) begin
            goto(p);
            checks++; if (dp_out !== (((p / 8) % 4) == 2)) $display("FAIL dp p=%0d: got %b want %b", p, dp_out, (((p / 8) % 4) == 2)); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_lz_blank();
        test_snapshot();
        test_all_disabled();
        test_mid_reset();
        test_dp();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
